// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR coefficient-load controller.
package fir_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned DEF_FIR_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARMED  = 3'd2,
    SWAP   = 3'd3,
    SETTLE = 3'd4
  } state_t;

  // Address width for a given depth, never narrower than one bit
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Coefficient stream, commit/strobe control and shadow-bank write bus of fir_coef_ctrl.
interface fir_coef_ctrl_if import fir_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIR_DEPTH  = DEF_FIR_DEPTH
) ();

  localparam int unsigned ADDR_W = addr_w(FIR_DEPTH);

  logic                  i_load_start;
  logic                  i_abort;
  logic [DATA_WIDTH-1:0] iv_coef;
  logic                  i_coef_valid;
  logic                  o_coef_ready;
  logic                  i_commit;
  logic                  i_sample_strobe;
  logic [ADDR_W-1:0]     ov_wr_addr;
  logic [DATA_WIDTH-1:0] ov_wr_data;
  logic                  o_wr_en;
  logic                  o_bank_sel;
  logic                  o_out_mask;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_csum_err;

  modport master (
    output i_load_start, i_abort, iv_coef, i_coef_valid, i_commit, i_sample_strobe,
    input  o_coef_ready, ov_wr_addr, ov_wr_data, o_wr_en, o_bank_sel, o_out_mask,
           o_busy, o_done, o_csum_err
  );

  modport slave (
    input  i_load_start, i_abort, iv_coef, i_coef_valid, i_commit, i_sample_strobe,
    output o_coef_ready, ov_wr_addr, ov_wr_data, o_wr_en, o_bank_sel, o_out_mask,
           o_busy, o_done, o_csum_err
  );

endinterface

// File: rtl/fir_settle_counter.sv
// Loadable down-counter with strobe-gated decrement and zero flag; shared by
// the load beat count and the post-swap settle count.
module fir_settle_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  assign zero_c = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load / bank-swap controller for the double-buffered systolic FIR.
// Build option FIR_COEF_CHECKSUM_EN adds a trailing checksum beat to each load.
module fir_coef_ctrl import fir_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIR_DEPTH  = DEF_FIR_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fir_coef_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(FIR_DEPTH);
  localparam int unsigned CNT_W  = addr_w(FIR_DEPTH + 1);
`ifdef FIR_COEF_CHECKSUM_EN
  localparam int unsigned LAST_BEAT = FIR_DEPTH;
`else
  localparam int unsigned LAST_BEAT = FIR_DEPTH - 1;
`endif

  state_t                state, state_nx;
  logic                  cnt_load_c, cnt_dec_c, cnt_zero_c;
  logic [CNT_W-1:0]      cnt_val_c, cnt, beat_idx_c;
  logic                  beat_c, data_beat_c, csum_ok_c, toggle_c, done_c, commit_hit_c;
  logic                  commit_q, bank_sel_q, mask_q, done_q, ready_q, busy_q, wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // Counter holds beats remaining in LOAD and samples remaining in SETTLE
  fir_settle_counter #(.W(CNT_W)) u_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .dec      (cnt_dec_c),
    .count    (cnt),
    .zero_c   (cnt_zero_c)
  );

  assign beat_c       = (state == LOAD) && bus.i_coef_valid && !bus.i_abort;
  assign beat_idx_c   = CNT_W'(LAST_BEAT) - cnt;
  assign commit_hit_c = commit_q || bus.i_commit;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  csum_err_q;

  // Final beat carries the expected sum and is never written to the bank
  assign data_beat_c = beat_c && !cnt_zero_c;
  assign csum_ok_c   = (csum_q == bus.iv_coef);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else if (cnt_load_c && (state == IDLE)) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      if (data_beat_c) csum_q <= csum_q + bus.iv_coef;
      if (beat_c && cnt_zero_c && !csum_ok_c) csum_err_q <= 1'b1;
    end
  end

  assign bus.o_csum_err = csum_err_q;
`else
  assign data_beat_c    = beat_c;
  assign csum_ok_c      = 1'b1;
  assign bus.o_csum_err = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    cnt_load_c = 1'b0;
    cnt_val_c  = CNT_W'(LAST_BEAT);
    cnt_dec_c  = 1'b0;
    toggle_c   = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_load_start && !bus.i_abort) begin
          state_nx   = LOAD;
          cnt_load_c = 1'b1;
        end
      end
      LOAD: begin
        if (bus.i_abort) begin
          state_nx = IDLE;
        end else if (beat_c) begin
          cnt_dec_c = 1'b1;
          if (cnt_zero_c) state_nx = csum_ok_c ? ARMED : IDLE;
        end
      end
      ARMED: begin
        if (bus.i_abort)       state_nx = IDLE;
        else if (commit_hit_c) state_nx = SWAP;
      end
      SWAP: begin
        if (bus.i_abort) begin
          state_nx = IDLE;
        end else if (bus.i_sample_strobe) begin
          state_nx   = SETTLE;
          toggle_c   = 1'b1;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(FIR_DEPTH - 1);
        end
      end
      SETTLE: begin
        if (bus.i_sample_strobe) begin
          if (cnt_zero_c) begin
            state_nx = IDLE;
            done_c   = 1'b1;
          end else begin
            cnt_dec_c = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      commit_q   <= 1'b0;
      bank_sel_q <= 1'b0;
      mask_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state      <= state_nx;
      // Commit seen during LOAD/ARMED is held until the swap or an abort
      commit_q   <= (state_nx inside {LOAD, ARMED}) && (state != IDLE) && commit_hit_c;
      bank_sel_q <= bank_sel_q ^ toggle_c;
      if (toggle_c)    mask_q <= 1'b1;
      else if (done_c) mask_q <= 1'b0;
      done_q     <= done_c;
      ready_q    <= (state_nx == LOAD);
      busy_q     <= (state_nx != IDLE);
      wr_en_q    <= data_beat_c;
      if (data_beat_c) begin
        wr_addr_q <= ADDR_W'(beat_idx_c);
        wr_data_q <= bus.iv_coef;
      end
    end
  end

  assign bus.o_coef_ready = ready_q;
  assign bus.ov_wr_addr   = wr_addr_q;
  assign bus.ov_wr_data   = wr_data_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_bank_sel   = bank_sel_q;
  assign bus.o_out_mask   = mask_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl at FIR_DEPTH=8, DATA_WIDTH=24.
module tb_fir_coef_ctrl;
  import fir_pkg::*;

  localparam int unsigned DW = 24;
  localparam int unsigned FD = 8;
`ifdef FIR_COEF_CHECKSUM_EN
  localparam int NB = FD + 1;
`else
  localparam int NB = FD;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int masked;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  fir_coef_ctrl_if #(.DATA_WIDTH(DW), .FIR_DEPTH(FD)) bus ();

  fir_coef_ctrl #(.DATA_WIDTH(DW), .FIR_DEPTH(FD)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Record shadow-bank writes and done pulses away from the active edge
  always @(negedge i_clk) begin
    if (bus.o_wr_en) begin
      wa.push_back(32'(bus.ov_wr_addr));
      wd.push_back(32'(bus.ov_wr_data));
    end
    if (bus.o_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_writes(input int n, input int base);
    check("wr_count", 32'(wa.size()), 32'(n));
    for (int i = 0; i < wa.size() && i < n; i++) begin
      check("wr_addr", wa[i], 32'(i));
      check("wr_data", wd[i], 32'(base + i));
    end
  endtask

  // Start a load and stream base..base+FD-1 (plus checksum beat if built in)
  task automatic load_beats(input int base, input bit gaps, input bit bad_cs, input int commit_at);
    logic [23:0] sum;
    logic [23:0] v;
    int sent;
    bit skip;
    sum = '0;
    sent = 0;
    skip = 1'b0;
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    while (sent < NB) begin
      if (gaps && skip) begin
        bus.i_coef_valid = 1'b0;
        bus.iv_coef      = 24'hABCDEF;
      end else begin
        if (sent < int'(FD)) v = 24'(base + sent);
        else                 v = bad_cs ? sum - 24'd1 : sum;
        bus.i_coef_valid = 1'b1;
        bus.iv_coef      = v;
      end
      bus.i_commit = (sent == commit_at);
      tick();
      if (!(gaps && skip)) begin
        if (sent < int'(FD)) sum = sum + v;
        sent++;
      end
      skip = !skip;
    end
    bus.i_coef_valid = 1'b0;
    bus.i_commit     = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.i_commit = 1'b1;
    tick();
    bus.i_commit = 1'b0;
  endtask

  // Issue n one-cycle strobes, gap cycles apart; count strobes seen while masked
  task automatic strobes(input int n, input int gap, output int nmask);
    nmask = 0;
    for (int s = 0; s < n; s++) begin
      bus.i_sample_strobe = 1'b1;
      #1;
      if (bus.o_out_mask) nmask++;
      tick();
      bus.i_sample_strobe = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_load_start    = 1'b0;
    bus.i_abort         = 1'b0;
    bus.iv_coef         = '0;
    bus.i_coef_valid    = 1'b0;
    bus.i_commit        = 1'b0;
    bus.i_sample_strobe = 1'b0;
    tick();
    tick();
    check("rst_bank_sel", bus.o_bank_sel, 0);
    check("rst_mask", bus.o_out_mask, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_ready", bus.o_coef_ready, 0);
    check("rst_wr_en", bus.o_wr_en, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_csum_err", bus.o_csum_err, 0);
    i_rst = 1'b0;
    tick();

    // Basic load of 1..8
    wa.delete(); wd.delete();
    load_beats(1, 1'b0, 1'b0, -1);
    tick();
    check_writes(FD, 1);
    check("armed_busy", bus.o_busy, 1);
    check("armed_ready", bus.o_coef_ready, 0);
    check("armed_bank", bus.o_bank_sel, 0);
    check("armed_csum_err", bus.o_csum_err, 0);

    // Commit, then strobes every 3 cycles
    commit_pulse();
    check("swap_bank_pre", bus.o_bank_sel, 0);
    check("swap_mask_pre", bus.o_out_mask, 0);
    strobes(12, 3, masked);
    check("settle_masked", 32'(masked), 8);
    check("settle_done", 32'(done_cnt), 1);
    check("settle_bank", bus.o_bank_sel, 1);
    check("settle_busy", bus.o_busy, 0);
    check("settle_mask", bus.o_out_mask, 0);

    // Valid toggling 1010..., then abort while ARMED
    wa.delete(); wd.delete();
    load_beats(100, 1'b1, 1'b0, -1);
    tick();
    check_writes(FD, 100);
    check("gap_busy", bus.o_busy, 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("armed_abort_busy", bus.o_busy, 0);
    check("armed_abort_bank", bus.o_bank_sel, 1);

    // Abort after 5 beats, same cycle as a sixth valid beat
    wa.delete(); wd.delete();
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    check("load_ready", bus.o_coef_ready, 1);
    bus.i_coef_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.iv_coef = 24'(50 + i);
      tick();
    end
    bus.iv_coef = 24'd55;
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort      = 1'b0;
    bus.i_coef_valid = 1'b0;
    tick();
    check_writes(5, 50);
    check("abort_busy", bus.o_busy, 0);
    check("abort_ready", bus.o_coef_ready, 0);
    commit_pulse();
    tick();
    strobes(3, 2, masked);
    check("abort_commit_bank", bus.o_bank_sel, 1);
    check("abort_commit_mask", 32'(masked), 0);
    check("abort_commit_busy", bus.o_busy, 0);

    // Commit asserted mid-load is latched and honoured once ARMED
    load_beats(20, 1'b0, 1'b0, 3);
    tick();
    strobes(12, 3, masked);
    check("early_commit_masked", 32'(masked), 8);
    check("early_commit_bank", bus.o_bank_sel, 0);
    check("early_commit_done", 32'(done_cnt), 2);

    // Async reset while in SETTLE
    load_beats(30, 1'b0, 1'b0, -1);
    commit_pulse();
    strobes(1, 2, masked);
    check("pre_rst_mask", bus.o_out_mask, 1);
    check("pre_rst_busy", bus.o_busy, 1);
    check("pre_rst_bank", bus.o_bank_sel, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_mask", bus.o_out_mask, 0);
    check("async_rst_busy", bus.o_busy, 0);
    check("async_rst_bank", bus.o_bank_sel, 0);
    tick();
    i_rst = 1'b0;
    tick();

`ifdef FIR_COEF_CHECKSUM_EN
    // Wrong checksum: error flagged, no swap on commit
    wa.delete(); wd.delete();
    load_beats(1, 1'b0, 1'b1, -1);
    tick();
    check_writes(FD, 1);
    check("cs_bad_err", bus.o_csum_err, 1);
    check("cs_bad_busy", bus.o_busy, 0);
    commit_pulse();
    tick();
    strobes(2, 2, masked);
    check("cs_bad_bank", bus.o_bank_sel, 0);
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    check("cs_err_clear", bus.o_csum_err, 0);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
